// File: rtl/udp_char_ram_writer_pkg.sv
// ============================================================================
// Module  : udp_char_ram_writer_pkg
// Brief   : Shared constants, state encodings and helpers for the char RAM writer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package udp_char_ram_writer_pkg;

    localparam int unsigned c_RAM_AW  = 11;
    localparam int unsigned c_HDR_LEN = 4;
    localparam int unsigned c_ST_W    = 3;

    localparam logic [7:0]          c_MAGIC   = 8'hA5;
    localparam logic [c_RAM_AW-1:0] c_MAX_LEN = 11'd2047;

    localparam logic [c_ST_W-1:0] c_ST_IDLE     = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_HDR      = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_PAYLOAD  = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_TERM     = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_WAIT_EOF = 3'd4;
    localparam logic [c_ST_W-1:0] c_ST_DROP     = 3'd5;

    // Saturating add used by the dropped-packet counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/udp_char_ram_writer.sv
// ============================================================================
// Module  : udp_char_ram_writer
// Brief   : Parses UDP payloads (magic/channel/length header + chars) into the
//           OSD char RAM and flags when a complete string is committed.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_char_ram_writer
    import udp_char_ram_writer_pkg::*;
#(
    parameter logic [7:0]          MAGIC     = c_MAGIC,
    parameter logic [c_RAM_AW-1:0] MAX_LEN   = c_MAX_LEN,
    parameter logic                CH_FILTER = 1'b0
)(
    input  logic                sys_clk,
    input  logic                rst_n,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    input  logic                rx_sof,
    input  logic                rx_eof,
    input  logic                rx_err,
    input  logic [2:0]          ch_sel,
    output logic                ram_wr_en,
    output logic [c_RAM_AW-1:0] ram_wr_addr,
    output logic [7:0]          ram_wr_data,
    output logic                udp_rec_data_valid,
    output logic [2:0]          rec_ch,
    output logic [c_RAM_AW-1:0] rec_len,
    output logic [7:0]          drop_cnt
);

    logic [c_ST_W-1:0]   r_state;
    logic [c_ST_W-1:0]   w_state_nxt;
    logic [1:0]          r_hdr_cnt;
    logic [2:0]          r_ch;
    logic [15:0]         r_len;
    logic [c_RAM_AW-1:0] r_idx;
    logic                r_last_eof;
    logic                r_last_err;

    logic                r_wr_en;
    logic [c_RAM_AW-1:0] r_wr_addr;
    logic [7:0]          r_wr_data;
    logic                r_valid;
    logic [2:0]          r_rec_ch;
    logic [c_RAM_AW-1:0] r_rec_len;
    logic [7:0]          r_drop_cnt;

    logic                w_sof;
    logic                w_eof;
    logic                w_magic_ok;
    logic                w_restart_hdr;
    logic                w_restart_drop;
    logic [c_ST_W-1:0]   w_restart_state;
    logic [1:0]          w_abort_inc;
    logic [15:0]         w_len_full;
    logic                w_len_ok;
    logic                w_ch_ok;
    logic                w_hdr_last;
    logic                w_last_char;

    logic                w_wr_en;
    logic [c_RAM_AW-1:0] w_wr_addr;
    logic [7:0]          w_wr_data;
    logic                w_commit;
    logic                w_clr_valid;
    logic [1:0]          w_drop_inc;
    logic                w_start_hdr;
    logic                w_hdr_byte;
    logic                w_pay_start;
    logic                w_char;

    assign w_sof          = rx_valid & rx_sof;
    assign w_eof          = rx_valid & rx_eof;
    assign w_magic_ok     = (rx_data == MAGIC);
    // A start-of-frame byte is parsed as a fresh header; a lone sof+eof byte is a runt.
    assign w_restart_hdr  = ~rx_eof & w_magic_ok;
    assign w_restart_drop = rx_eof | ~w_magic_ok;
    assign w_restart_state = rx_eof ? c_ST_IDLE : (w_magic_ok ? c_ST_HDR : c_ST_DROP);
    assign w_abort_inc    = 2'd1 + {1'b0, w_restart_drop};

    assign w_len_full  = {r_len[15:8], rx_data};
    assign w_len_ok    = (w_len_full != 16'd0) && (w_len_full <= {5'd0, MAX_LEN});
    assign w_ch_ok     = !CH_FILTER || (r_ch == ch_sel);
    assign w_hdr_last  = (r_hdr_cnt == 2'(c_HDR_LEN - 1));
    assign w_last_char = (r_idx == (r_len[c_RAM_AW-1:0] - 11'd1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_sof) w_state_nxt = w_restart_state;
            end
            c_ST_HDR: begin
                if (w_sof)                  w_state_nxt = w_restart_state;
                else if (w_eof)             w_state_nxt = c_ST_IDLE;
                else if (rx_valid && w_hdr_last)
                    w_state_nxt = (w_len_ok && w_ch_ok) ? c_ST_PAYLOAD : c_ST_DROP;
            end
            c_ST_PAYLOAD: begin
                if (w_sof)                  w_state_nxt = w_restart_state;
                else if (rx_valid && w_last_char) w_state_nxt = c_ST_TERM;
                else if (w_eof)             w_state_nxt = c_ST_IDLE;
            end
            c_ST_TERM: begin
                if (r_last_eof)             w_state_nxt = w_sof ? w_restart_state : c_ST_IDLE;
                else if (w_sof)             w_state_nxt = w_restart_state;
                else if (w_eof)             w_state_nxt = c_ST_IDLE;
                else                        w_state_nxt = c_ST_WAIT_EOF;
            end
            c_ST_WAIT_EOF, c_ST_DROP: begin
                if (w_sof)                  w_state_nxt = w_restart_state;
                else if (w_eof)             w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_addr   = '0;
        w_wr_data   = '0;
        w_commit    = 1'b0;
        w_clr_valid = 1'b0;
        w_drop_inc  = 2'd0;
        w_start_hdr = 1'b0;
        w_hdr_byte  = 1'b0;
        w_pay_start = 1'b0;
        w_char      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_sof) begin
                    w_start_hdr = w_restart_hdr;
                    w_drop_inc  = {1'b0, w_restart_drop};
                end
            end
            c_ST_HDR: begin
                if (w_sof) begin
                    w_start_hdr = w_restart_hdr;
                    w_drop_inc  = w_abort_inc;
                end else if (w_eof) begin
                    w_drop_inc = 2'd1;
                end else if (rx_valid) begin
                    w_hdr_byte = 1'b1;
                    if (w_hdr_last) begin
                        if (w_len_ok && w_ch_ok) begin
                            w_pay_start = 1'b1;
                            w_clr_valid = 1'b1;
                        end else begin
                            w_drop_inc = 2'd1;
                        end
                    end
                end
            end
            c_ST_PAYLOAD: begin
                if (w_sof) begin
                    w_start_hdr = w_restart_hdr;
                    w_drop_inc  = w_abort_inc;
                end else if (rx_valid) begin
                    w_char    = 1'b1;
                    w_wr_en   = 1'b1;
                    w_wr_addr = r_idx;
                    w_wr_data = rx_data;
                    if (rx_eof && !w_last_char) w_drop_inc = 2'd1;
                end
            end
            c_ST_TERM: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_len[c_RAM_AW-1:0];
                w_wr_data = 8'h00;
                // Eof already arrived with the last char: finish with its latched error.
                if (r_last_eof) begin
                    w_commit = ~r_last_err;
                    if (w_sof) begin
                        w_start_hdr = w_restart_hdr;
                        w_drop_inc  = {1'b0, r_last_err} + {1'b0, w_restart_drop};
                    end else begin
                        w_drop_inc  = {1'b0, r_last_err};
                    end
                end else if (w_sof) begin
                    w_start_hdr = w_restart_hdr;
                    w_drop_inc  = w_abort_inc;
                end else if (w_eof) begin
                    w_commit   = ~rx_err;
                    w_drop_inc = {1'b0, rx_err};
                end
            end
            c_ST_WAIT_EOF: begin
                if (w_sof) begin
                    w_start_hdr = w_restart_hdr;
                    w_drop_inc  = w_abort_inc;
                end else if (w_eof) begin
                    w_commit   = ~rx_err;
                    w_drop_inc = {1'b0, rx_err};
                end
            end
            c_ST_DROP: begin
                // Packet was already counted on entry; only a new sof can count again.
                if (w_sof) begin
                    w_start_hdr = w_restart_hdr;
                    w_drop_inc  = {1'b0, w_restart_drop};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_cnt  <= '0;
            r_ch       <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_last_eof <= 1'b0;
            r_last_err <= 1'b0;
        end else begin
            if (w_start_hdr) begin
                r_hdr_cnt <= 2'd1;
            end else if (w_hdr_byte) begin
                r_hdr_cnt <= r_hdr_cnt + 2'd1;
                case (r_hdr_cnt)
                    2'd1:    r_ch        <= rx_data[2:0];
                    2'd2:    r_len[15:8] <= rx_data;
                    2'd3:    r_len[7:0]  <= rx_data;
                    default: ;
                endcase
            end
            if (w_pay_start) begin
                r_idx <= '0;
            end else if (w_char) begin
                r_idx <= r_idx + 11'd1;
            end
            if (w_char) begin
                r_last_eof <= rx_eof;
                r_last_err <= rx_err;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_valid    <= 1'b0;
            r_rec_ch   <= '0;
            r_rec_len  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_en    <= w_wr_en;
            r_wr_addr  <= w_wr_addr;
            r_wr_data  <= w_wr_data;
            r_drop_cnt <= sat_add8(r_drop_cnt, w_drop_inc);
            if (w_clr_valid) begin
                r_valid <= 1'b0;
            end else if (w_commit) begin
                r_valid   <= 1'b1;
                r_rec_ch  <= r_ch;
                r_rec_len <= r_len[c_RAM_AW-1:0];
            end
        end
    end

    assign ram_wr_en          = r_wr_en;
    assign ram_wr_addr        = r_wr_addr;
    assign ram_wr_data        = r_wr_data;
    assign udp_rec_data_valid = r_valid;
    assign rec_ch             = r_rec_ch;
    assign rec_len            = r_rec_len;
    assign drop_cnt           = r_drop_cnt;

endmodule

`default_nettype wire
